fetch_redirect_pcgen: RTL and testbench
=======================================

Name: fetch_redirect_pcgen

Overview:
- Front-end PC generator and consumer of the dual-way jump redirect (way0/way1 jumpFlag/jumpAddr pair) produced by the execute-side jump controller.
- Issues 64-bit aligned fetch requests covering two instructions (way0 at PC, way1 at PC+4).
- Buffers one fetched pair for the decoder and redirects on a jump.
- On a jump it flushes the buffered pair and discards any in-flight stale response.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset; bits [2:0] must be 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- way0_jumpFlag_i  in  1  redirect request, way0 copy
- way0_jumpAddr_i  in  32  redirect target, way0 copy
- way1_jumpFlag_i  in  1  redirect request, way1 copy
- way1_jumpAddr_i  in  32  way1 copy; equals way0_jumpAddr_i+4 when valid
- ifReqValid_o  out  1  fetch request valid
- ifReqAddr_o  out  32  fetch address, bits [2:0]=0
- ifReqReady_i  in  1  fetch request accepted
- ifRspValid_i  in  1  fetch response valid, one cycle, always accepted
- ifRspData_i  in  64  [31:0] inst at addr, [63:32] inst at addr+4
- outValid_o  out  1  instruction pair valid to decode
- outReady_i  in  1  decode accepts pair
- way0_inst_o / way1_inst_o  out  32 each  instructions
- way0_pc_o / way1_pc_o  out  32 each  PCs, way1 = way0+4
- way0_valid_o / way1_valid_o  out  1 each  per-slot valid, qualified by outValid_o
- flush_o  out  1  one-cycle pulse, downstream discards younger state

Behaviour:
- Reset (async assert, sync release): state BOOT, pc=RESET_PC, drop=0, skipSlot0=0. All outputs 0.
- redirect = way0_jumpFlag_i | way1_jumpFlag_i. target = way0_jumpFlag_i ? way0_jumpAddr_i : way1_jumpAddr_i-4. target bits [1:0] are ignored.
- States:
  - BOOT: one idle cycle, then REQ.
  - REQ: ifReqValid_o=1, ifReqAddr_o=pc. On ifReqReady_i go to WAIT.
  - WAIT: await ifRspValid_i. On response, if drop=1 clear drop and go to REQ (response discarded). Otherwise latch data into the buffer and go to HOLD.
  - HOLD: outValid_o=1. On outReady_i: pc += 8, skipSlot0 = 0, go to REQ.
- Slot valids: way0_valid_o = !skipSlot0, way1_valid_o = 1. way0_pc_o = pc, way1_pc_o = pc+4.
- Redirect has the highest priority in every state except BOOT (ignored in BOOT). On redirect in cycle N:
  - pc <= {target[31:3],3'b0}; skipSlot0 <= target[2].
  - Buffer invalidated; flush_o=1 in N+1.
  - State REQ in N+1, so ifReqValid_o=1 with the new address in N+1.
- drop set on redirect:
  - drop <= 1 if the state is WAIT with no ifRspValid_i in N.
  - drop <= 1 if the state is REQ with ifReqReady_i=1 in N (request accepted, response now stale).
  - A response arriving in N together with the redirect is discarded and does not set drop.
- HOLD with outReady_i and redirect in the same cycle: the pair is still consumed (handshake completes) and the redirect wins for the next pc. flush_o in N+1 does not retract the consumed pair.
- While drop=1, the next request may be accepted but its response is not; the counter holds at most one stale response. A redirect while drop=1 keeps drop=1.
- pc wraps modulo 2^32: 32'hFFFF_FFF8 + 8 = 0.
- Maximum one outstanding request.
- Throughput: at most one pair per 3 cycles with ready=1 and zero-latency memory.

Optional Feature:
- JUMP_CHECK_EN: adds port redirectErr_o (out, 1). It is a sticky flag set when both jump flags are high and they disagree on the target: way1_jumpAddr_i != way0_jumpAddr_i+4. Also set when exactly one flag is high in a cycle where the producer guarantees both are equal. Cleared only by reset.
- Without the macro: port absent and no checking logic.

Test Plan:
- Reset release, ifReqReady_i=1, response 2 cycles later → first ifReqAddr_o=32'h8000_0000. Pair output with way0_pc_o=32'h8000_0000, way1_pc_o=32'h8000_0004, next request 32'h8000_0008.
- way0_jumpFlag_i=1, way0_jumpAddr_i=32'h8000_1000 during HOLD → flush_o pulse next cycle, outValid_o=0, next ifReqAddr_o=32'h8000_1000.
- Redirect to 32'h8000_2004 → ifReqAddr_o=32'h8000_2000, way0_valid_o=0, way1_valid_o=1, way1_pc_o=32'h8000_2004. The following pair has both valid at 32'h8000_2008.
- Redirect to 32'h8000_3000 while in WAIT → the old response (data 64'hDEAD...) is not presented, then a fresh request to 32'h8000_3000 is presented.
- Only way1_jumpFlag_i=1, way1_jumpAddr_i=32'h8000_4004 → target 32'h8000_4000, both slots valid.
- With JUMP_CHECK_EN: both flags high, way0 addr 32'h100, way1 addr 32'h200 → redirectErr_o=1 and stays 1 until rst_n asserted.

Source files
------------

// File: rtl/fetch_redirect_pcgen_if.sv
// Jump-redirect inputs, single-outstanding fetch bus and decode-side instruction pair
// of fetch_redirect_pcgen. master = PC generator, slave = its environment.
interface fetch_redirect_pcgen_if;
   logic        way0_jumpFlag_i;
   logic [31:0] way0_jumpAddr_i;
   logic        way1_jumpFlag_i;
   logic [31:0] way1_jumpAddr_i;
   logic        ifReqValid_o;
   logic [31:0] ifReqAddr_o;
   logic        ifReqReady_i;
   logic        ifRspValid_i;
   logic [63:0] ifRspData_i;
   logic        outValid_o;
   logic        outReady_i;
   logic [31:0] way0_inst_o;
   logic [31:0] way1_inst_o;
   logic [31:0] way0_pc_o;
   logic [31:0] way1_pc_o;
   logic        way0_valid_o;
   logic        way1_valid_o;
   logic        flush_o;

   modport master (
      input  way0_jumpFlag_i, way0_jumpAddr_i, way1_jumpFlag_i, way1_jumpAddr_i,
      input  ifReqReady_i, ifRspValid_i, ifRspData_i, outReady_i,
      output ifReqValid_o, ifReqAddr_o, outValid_o, way0_inst_o, way1_inst_o,
      output way0_pc_o, way1_pc_o, way0_valid_o, way1_valid_o, flush_o
   );

   modport slave (
      output way0_jumpFlag_i, way0_jumpAddr_i, way1_jumpFlag_i, way1_jumpAddr_i,
      output ifReqReady_i, ifRspValid_i, ifRspData_i, outReady_i,
      input  ifReqValid_o, ifReqAddr_o, outValid_o, way0_inst_o, way1_inst_o,
      input  way0_pc_o, way1_pc_o, way0_valid_o, way1_valid_o, flush_o
   );
endinterface

// File: rtl/fetch_redirect_pcgen.sv
// Front-end PC generator: fetches aligned instruction pairs, buffers one, redirects on jumps.
// Optional macro JUMP_CHECK_EN adds sticky redirectErr_o for inconsistent way0/way1 jump copies.
module fetch_redirect_pcgen #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic clk,
   input  logic rst_n,
`ifdef JUMP_CHECK_EN
   output logic redirectErr_o,
`endif
   fetch_redirect_pcgen_if.master bus
);

   typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

   state_t      r_state, w_state_next;
   logic [31:0] r_pc;
   logic        r_skip;
   logic        r_drop;
   logic        r_flush;
   logic [63:0] r_buf;
   logic        w_redirect;
   logic        w_stale;
   logic [31:0] w_target;

   logic        w_req_valid, w_out_valid, w_way0_valid, w_way1_valid;
   logic [31:0] w_req_addr, w_way0_pc, w_way1_pc, w_way0_inst, w_way1_inst;

   assign w_redirect = (r_state != BOOT) && (bus.way0_jumpFlag_i || bus.way1_jumpFlag_i);
   assign w_target   = bus.way0_jumpFlag_i ? bus.way0_jumpAddr_i : (bus.way1_jumpAddr_i - 32'd4);
   // An accepted-but-unanswered request at redirect time will return stale data later.
   assign w_stale    = ((r_state == WAIT) && !bus.ifRspValid_i) ||
                       ((r_state == REQ) && bus.ifReqReady_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BOOT;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_redirect) begin
         w_state_next = REQ;
      end else begin
         case (r_state)
            BOOT:    w_state_next = REQ;
            REQ:     if (bus.ifReqReady_i) w_state_next = WAIT;
            WAIT:    if (bus.ifRspValid_i) w_state_next = r_drop ? REQ : HOLD;
            HOLD:    if (bus.outReady_i) w_state_next = REQ;
            default: w_state_next = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_skip  <= 1'b0;
         r_drop  <= 1'b0;
         r_flush <= 1'b0;
         r_buf   <= '0;
      end else begin
         r_flush <= w_redirect;
         if (w_redirect) begin
            r_pc   <= w_target & ~32'h7;
            r_skip <= w_target[2];
            r_drop <= r_drop | w_stale;
         end else if (r_state == WAIT && bus.ifRspValid_i) begin
            if (r_drop) r_drop <= 1'b0;
            else        r_buf  <= bus.ifRspData_i;
         end else if (r_state == HOLD && bus.outReady_i) begin
            r_pc   <= r_pc + 32'd8;
            r_skip <= 1'b0;
         end
      end
   end

   always_comb begin
      w_req_valid  = 1'b0;
      w_req_addr   = '0;
      w_out_valid  = 1'b0;
      w_way0_valid = 1'b0;
      w_way1_valid = 1'b0;
      w_way0_pc    = '0;
      w_way1_pc    = '0;
      w_way0_inst  = '0;
      w_way1_inst  = '0;
      case (r_state)
         REQ: begin
            w_req_valid = 1'b1;
            w_req_addr  = r_pc;
         end
         HOLD: begin
            w_out_valid  = 1'b1;
            w_way0_valid = !r_skip;
            w_way1_valid = 1'b1;
            w_way0_pc    = r_pc;
            w_way1_pc    = r_pc + 32'd4;
            w_way0_inst  = r_buf[31:0];
            w_way1_inst  = r_buf[63:32];
         end
         default: ;
      endcase
   end

   assign bus.ifReqValid_o = w_req_valid;
   assign bus.ifReqAddr_o  = w_req_addr;
   assign bus.outValid_o   = w_out_valid;
   assign bus.way0_valid_o = w_way0_valid;
   assign bus.way1_valid_o = w_way1_valid;
   assign bus.way0_pc_o    = w_way0_pc;
   assign bus.way1_pc_o    = w_way1_pc;
   assign bus.way0_inst_o  = w_way0_inst;
   assign bus.way1_inst_o  = w_way1_inst;
   assign bus.flush_o      = r_flush;

`ifdef JUMP_CHECK_EN
   logic r_err;
   logic w_err_cond;

   // The producer drives both copies together, so a lone flag or a target mismatch is an error.
   assign w_err_cond = (bus.way0_jumpFlag_i ^ bus.way1_jumpFlag_i) ||
                       (bus.way0_jumpFlag_i && bus.way1_jumpFlag_i &&
                        (bus.way1_jumpAddr_i != bus.way0_jumpAddr_i + 32'd4));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_err <= 1'b0;
      else if (w_err_cond) r_err <= 1'b1;
   end

   assign redirectErr_o = r_err;
`endif

endmodule

// File: tb/tb_fetch_redirect_pcgen.sv
// Randomized scoreboard bench for fetch_redirect_pcgen: single-outstanding memory model,
// random redirects, and a monitor that tracks the expected PC stream.
module tb_fetch_redirect_pcgen;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int N_CYC = 4000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_redirect_pcgen_if bus();
`ifdef JUMP_CHECK_EN
   logic redirectErr_o;
`endif

   fetch_redirect_pcgen #(.RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef JUMP_CHECK_EN
      .redirectErr_o(redirectErr_o),
`endif
      .bus(bus)
   );

   typedef struct {
      int unsigned cyc;
      logic [31:0] tgt;
      bit          bad;
   } redir_t;

   redir_t      redir_q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          handshakes = 0;
   bit          done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Driver: memory responder, decode back-pressure and redirect stimulus.
   initial begin
      bit          acc_prev = 0;
      logic [31:0] acc_addr = '0;
      bit          pend = 0;
      logic [31:0] pend_addr = '0;
      int          lat = 0;
      int          k = 0;
      int          mode;
      logic [31:0] t, a0, a1;
      bit          f0, f1, bad;
      int          dir_mode[6];
      logic [31:0] dir_tgt[6];
      redir_t      r;

      dir_mode = '{0, 0, 0, 1, 2, 0};
      dir_tgt  = '{32'h8000_1000, 32'h8000_2004, 32'h8000_3000,
                   32'h8000_4000, 32'hFFFF_FFF8, 32'hFFFF_FFFC};

      bus.way0_jumpFlag_i = 0; bus.way0_jumpAddr_i = '0;
      bus.way1_jumpFlag_i = 0; bus.way1_jumpAddr_i = '0;
      bus.ifReqReady_i = 0; bus.ifRspValid_i = 0; bus.ifRspData_i = '0;
      bus.outReady_i = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", bus.ifReqValid_o, 0);
      check("rst_req_addr", bus.ifReqAddr_o, 0);
      check("rst_out_valid", bus.outValid_o, 0);
      check("rst_flush", bus.flush_o, 0);
      check("rst_slot_valids", {bus.way0_valid_o, bus.way1_valid_o}, 0);
      check("rst_way0_pc", bus.way0_pc_o, 0);
      @(posedge clk); #2;
      rst_n = 1;

      for (int i = 0; i < N_CYC; i++) begin
         @(posedge clk); #2;
         if (acc_prev) begin
            pend = 1;
            pend_addr = acc_addr;
            lat = $urandom_range(0, 2);
         end
         bus.ifRspValid_i = 0;
         bus.ifRspData_i  = 64'hDEAD_BEEF_DEAD_BEEF;
         if (pend) begin
            if (lat == 0) begin
               bus.ifRspValid_i = 1;
               bus.ifRspData_i  = {inst_of(pend_addr + 32'd4), inst_of(pend_addr)};
               pend = 0;
            end else begin
               lat--;
            end
         end
         bus.ifReqReady_i = !pend && ($urandom_range(0, 3) != 0);
         bus.outReady_i   = ($urandom_range(0, 2) != 0);

         f0 = 0; f1 = 0; bad = 0;
         a0 = $urandom(); a1 = $urandom();
         if (i >= 4 && $urandom_range(0, 9) == 0) begin
            if (k < 6) begin
               mode = dir_mode[k];
               t = dir_tgt[k];
               k++;
            end else begin
               mode = $urandom_range(0, 2);
               t = $urandom();
               if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8 | {29'd0, t[2:0]};
            end
            f0 = (mode != 1);
            f1 = (mode != 0);
            if (f0) a0 = t;
            if (f1) a1 = t + 32'd4;
`ifdef JUMP_CHECK_EN
            if (mode == 2 && $urandom_range(0, 3) == 0) a1 = t + 32'h100;
            bad = (f0 != f1) || (a1 != t + 32'd4);
`endif
            r.cyc = cyc; r.tgt = t; r.bad = bad;
            redir_q.push_back(r);
         end
         bus.way0_jumpFlag_i = f0; bus.way0_jumpAddr_i = a0;
         bus.way1_jumpFlag_i = f1; bus.way1_jumpAddr_i = a1;

         acc_prev = bus.ifReqValid_o && bus.ifReqReady_i;
         acc_addr = bus.ifReqAddr_o;
      end

      @(posedge clk); #2;
      bus.way0_jumpFlag_i = 0;
      bus.way1_jumpFlag_i = 0;
      done = 1;
      repeat (2) @(posedge clk);
      check("handshake_count_min100", (handshakes >= 100) ? 1 : 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Monitor: compares DUT outputs against the expected PC stream every cycle.
   initial begin
      logic [31:0] exp_pc = RESET_PC;
      bit          exp_skip = 0;
      bit          exp_err = 0;
      bit          redir_last = 0;
      bit          redir_now;
      redir_t      r;

      wait (rst_n === 1'b1);
      while (!done) begin
         @(negedge clk);
         redir_now = 0;
         if (redir_q.size() > 0 && redir_q[0].cyc == cyc) begin
            r = redir_q.pop_front();
            redir_now = 1;
         end

         check("flush", bus.flush_o, redir_last);
         if (redir_last) begin
            check("out_after_redir", bus.outValid_o, 0);
            check("req_after_redir", bus.ifReqValid_o, 1);
         end
         if (bus.ifReqValid_o) check("req_addr", bus.ifReqAddr_o, exp_pc);
         if (bus.outValid_o) begin
            check("way0_pc", bus.way0_pc_o, exp_pc);
            check("way1_pc", bus.way1_pc_o, exp_pc + 32'd4);
            check("way0_inst", bus.way0_inst_o, inst_of(exp_pc));
            check("way1_inst", bus.way1_inst_o, inst_of(exp_pc + 32'd4));
            check("way0_valid", bus.way0_valid_o, !exp_skip);
            check("way1_valid", bus.way1_valid_o, 1);
         end
`ifdef JUMP_CHECK_EN
         check("redirect_err", redirectErr_o, exp_err);
`endif

         if (bus.outValid_o && bus.outReady_i) begin
            handshakes++;
            exp_pc   = exp_pc + 32'd8;
            exp_skip = 0;
         end
         if (redir_now) begin
            exp_pc   = r.tgt & ~32'h7;
            exp_skip = r.tgt[2];
            exp_err  = exp_err | r.bad;
         end
         redir_last = redir_now;
      end
   end
endmodule
